// File: rtl/ltc_core_scheduler.sv
// ltc_core_scheduler: broadcasts work to NCORES hashcores, waits for them to
// settle, tracks nonce-space exhaustion and funnels golden nonces from
// per-core one-entry holding slots into one round-robin output register.
module ltc_core_scheduler #(
  parameter int NCORES     = 4,
  parameter int DATA_W     = 256,
  parameter int SETTLE_CYC = 8
) (
  input  logic                   hash_clk,
  input  logic                   reset_n,
  input  logic                   work_valid,
  input  logic [DATA_W-1:0]      work_data,
  input  logic [3:0]             work_id,
  output logic                   work_ready,
  output logic                   core_load,
  output logic [DATA_W-1:0]      core_data,
  output logic [4*NCORES-1:0]    core_nonce_msb,
  input  logic [NCORES-1:0]      core_golden,
  input  logic [32*NCORES-1:0]   core_nonce,
  input  logic [NCORES-1:0]      core_wrapped,
  output logic                   out_valid,
  output logic [31:0]            out_nonce,
  output logic [3:0]             out_id,
  input  logic                   out_ready,
  output logic                   exhausted,
  output logic                   overflow
);

  localparam int RR_W  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [RR_W-1:0]  RR_LAST     = RR_W'(NCORES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

  state_t              state_q;
  logic                work_ready_q;
  logic                core_load_q;
  logic [DATA_W-1:0]   core_data_q;
  logic [3:0]          id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NCORES-1:0]   wrapped_q;
  logic                exhausted_q;
  logic                wrapped_all;

  // Holding slots, one per core
  logic [NCORES-1:0]         slot_full_q, slot_full_d;
  logic [NCORES-1:0][31:0]   slot_nonce_q, slot_nonce_d;
  logic [NCORES-1:0][3:0]    slot_id_q, slot_id_d;

  // Output stage
  logic                out_valid_q;
  logic [31:0]         out_nonce_q;
  logic [3:0]          out_id_q;
  logic                overflow_q;
  logic [RR_W-1:0]     rr_q;

  logic [NCORES-1:0]        golden_run;
  logic [NCORES-1:0]        avail;
  logic [NCORES-1:0]        take;
  logic [NCORES-1:0]        load_new;
  logic [NCORES-1:0]        drop;
  logic [NCORES-1:0][31:0]  cand_nonce;
  logic [NCORES-1:0][3:0]   cand_id;
  logic                     out_load;
  logic                     win_found;
  logic [RR_W-1:0]          win_idx;
  logic [RR_W-1:0]          rr_next;

  assign wrapped_all = &(wrapped_q | core_wrapped);
  assign out_load    = !out_valid_q || out_ready;
  assign rr_next     = (win_idx == RR_LAST) ? '0 : win_idx + 1'b1;

  // Per-core wiring: constant prefixes, candidate selection and slot next-state.
  // A golden pulse on an empty slot may bypass straight into the output
  // register; a full slot is older than any incoming pulse so it wins.
  for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
    assign core_nonce_msb[4*gi +: 4] = 4'(gi);
    assign golden_run[gi] = core_golden[gi] && (state_q == S_RUN);
    assign avail[gi]      = slot_full_q[gi] || golden_run[gi];
    assign cand_nonce[gi] = slot_full_q[gi] ? slot_nonce_q[gi] : core_nonce[32*gi +: 32];
    assign cand_id[gi]    = slot_full_q[gi] ? slot_id_q[gi] : id_q;
    assign take[gi]       = out_load && win_found && (win_idx == RR_W'(gi));
    assign load_new[gi]   = golden_run[gi] && (slot_full_q[gi] ? take[gi] : !take[gi]);
    assign drop[gi]       = golden_run[gi] && slot_full_q[gi] && !take[gi];
    assign slot_full_d[gi]  = slot_full_q[gi] ? (!take[gi] || golden_run[gi])
                                              : (golden_run[gi] && !take[gi]);
    assign slot_nonce_d[gi] = load_new[gi] ? core_nonce[32*gi +: 32] : slot_nonce_q[gi];
    assign slot_id_d[gi]    = load_new[gi] ? id_q : slot_id_q[gi];
  end

  // Round-robin search: first available core at or after rr_q
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NCORES; k++) begin
      automatic int idx = int'(rr_q) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (!win_found && avail[idx]) begin
        win_found = 1'b1;
        win_idx   = RR_W'(idx);
      end
    end
  end

  // Work sequencing FSM with registered handshake/load outputs
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      work_ready_q <= 1'b1;
      core_load_q  <= 1'b0;
      core_data_q  <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      wrapped_q    <= '0;
      exhausted_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (work_valid) begin
            state_q      <= S_LOAD;
            work_ready_q <= 1'b0;
            core_load_q  <= 1'b1;
            core_data_q  <= work_data;
            id_q         <= work_id;
          end
        end
        S_LOAD: begin
          state_q     <= S_SETTLE;
          core_load_q <= 1'b0;
          cnt_q       <= SETTLE_LAST;
          wrapped_q   <= '0;
          exhausted_q <= 1'b0;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q      <= S_RUN;
            work_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          wrapped_q <= wrapped_q | core_wrapped;
          if (work_valid) begin
            state_q      <= S_LOAD;
            work_ready_q <= 1'b0;
            core_load_q  <= 1'b1;
            core_data_q  <= work_data;
            id_q         <= work_id;
          end else if (wrapped_all) begin
            state_q     <= S_IDLE;
            exhausted_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Holding slots and sticky drop flag
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_full_q  <= '0;
      slot_nonce_q <= '0;
      slot_id_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      slot_full_q  <= slot_full_d;
      slot_nonce_q <= slot_nonce_d;
      slot_id_q    <= slot_id_d;
      overflow_q   <= overflow_q || (|drop);
    end
  end

  // Output register: refills whenever empty or being consumed
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_nonce_q <= '0;
      out_id_q    <= '0;
      rr_q        <= '0;
    end else if (out_load) begin
      if (win_found) begin
        out_valid_q <= 1'b1;
        out_nonce_q <= cand_nonce[win_idx];
        out_id_q    <= cand_id[win_idx];
        rr_q        <= rr_next;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign work_ready = work_ready_q;
  assign core_load  = core_load_q;
  assign core_data  = core_data_q;
  assign out_valid  = out_valid_q;
  assign out_nonce  = out_nonce_q;
  assign out_id     = out_id_q;
  assign exhausted  = exhausted_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ltc_core_scheduler.sv
// Directed testbench for ltc_core_scheduler (NCORES=4, SETTLE_CYC=8).
module tb_ltc_core_scheduler;

  localparam int NC = 4;
  localparam int DW = 32;

  logic            hash_clk = 1'b0;
  logic            reset_n  = 1'b0;
  logic            work_valid = 1'b0;
  logic [DW-1:0]   work_data  = '0;
  logic [3:0]      work_id    = '0;
  logic            work_ready;
  logic            core_load;
  logic [DW-1:0]   core_data;
  logic [4*NC-1:0] core_nonce_msb;
  logic [NC-1:0]   core_golden  = '0;
  logic [32*NC-1:0] core_nonce  = '0;
  logic [NC-1:0]   core_wrapped = '0;
  logic            out_valid;
  logic [31:0]     out_nonce;
  logic [3:0]      out_id;
  logic            out_ready = 1'b1;
  logic            exhausted;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  ltc_core_scheduler #(.NCORES(NC), .DATA_W(DW), .SETTLE_CYC(8)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n),
    .work_valid(work_valid), .work_data(work_data), .work_id(work_id),
    .work_ready(work_ready), .core_load(core_load), .core_data(core_data),
    .core_nonce_msb(core_nonce_msb), .core_golden(core_golden),
    .core_nonce(core_nonce), .core_wrapped(core_wrapped),
    .out_valid(out_valid), .out_nonce(out_nonce), .out_id(out_id),
    .out_ready(out_ready), .exhausted(exhausted), .overflow(overflow)
  );

  always #5 hash_clk = ~hash_clk;

  typedef struct {
    logic        wv;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  gold;
    logic [3:0]  wrap;
    logic        ordy;
    logic [31:0] nbase;
    logic        e_ready;
    logic        e_load;
    logic        e_ov;
    logic [31:0] e_nonce;
    logic [3:0]  e_id;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic wv, logic [3:0] wid, logic [31:0] wdata,
                              logic [3:0] gold, logic [3:0] wrap, logic ordy,
                              logic [31:0] nbase, logic e_ready, logic e_load,
                              logic e_ov, logic [31:0] e_nonce, logic [3:0] e_id);
    vec_t v;
    v.wv = wv; v.wid = wid; v.wdata = wdata; v.gold = gold; v.wrap = wrap;
    v.ordy = ordy; v.nbase = nbase; v.e_ready = e_ready; v.e_load = e_load;
    v.e_ov = e_ov; v.e_nonce = e_nonce; v.e_id = e_id;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [3:0] wid, input logic [31:0] wdata,
                       input logic [3:0] gold, input logic [3:0] wrap, input logic ordy,
                       input logic [31:0] nbase);
    work_valid   = wv;
    work_id      = wid;
    work_data    = wdata;
    core_golden  = gold;
    core_wrapped = wrap;
    out_ready    = ordy;
    for (int i = 0; i < NC; i++) core_nonce[32*i +: 32] = nbase + 32'(i);
  endtask

  task automatic step();
    @(posedge hash_clk);
    #1;
  endtask

  initial begin
    // Table: acceptance latency, settle window, round-robin order, old-id tagging
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 4'b0000, 0, 1, 32'h0,        0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 4'b0010, 0, 1, 32'h1100,                 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    1, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 4'b0001, 0, 1, 32'h2000,                 1, 0, 1, 32'h2000, 5);
    vecs[11] = mk(0, 0, 0, 4'b0010, 0, 1, 32'h2100,                 1, 0, 1, 32'h2101, 5);
    vecs[12] = mk(0, 0, 0, 4'b1101, 0, 1, 32'h3000,                 1, 0, 1, 32'h3002, 5);
    vecs[13] = mk(0, 0, 0, 4'b0000, 0, 1, 32'h77770000,             1, 0, 1, 32'h3003, 5);
    vecs[14] = mk(0, 0, 0, 4'b0000, 0, 1, 32'h77770000,             1, 0, 1, 32'h3000, 5);
    vecs[15] = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    1, 0, 0, 0, 0);
    vecs[16] = mk(1, 6, 32'hCAFEF00D, 4'b0100, 0, 1, 32'h5000,      0, 1, 1, 32'h5002, 5);
    for (int r = 17; r <= 24; r++)
      vecs[r] = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                   0, 0, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 4'b0000, 0, 1, 32'h0,                    1, 0, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 4'b0010, 0, 1, 32'h6000,                 1, 0, 1, 32'h6001, 6);

    // Reset values
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    check("rst_work_ready", 32'(work_ready), 1);
    check("rst_core_load", 32'(core_load), 0);
    check("rst_core_data", core_data, 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_nonce", out_nonce, 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_exhausted", 32'(exhausted), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("nonce_msb", 32'(core_nonce_msb), 32'h3210);
    reset_n = 1'b1;

    for (int r = 0; r < 27; r++) begin
      drive(vecs[r].wv, vecs[r].wid, vecs[r].wdata, vecs[r].gold, vecs[r].wrap,
            vecs[r].ordy, vecs[r].nbase);
      step();
      $display("row %0d: ready=%0b load=%0b out_valid=%0b nonce=%h id=%0d",
               r, work_ready, core_load, out_valid, out_nonce, out_id);
      check($sformatf("row%0d_work_ready", r), 32'(work_ready), 32'(vecs[r].e_ready));
      check($sformatf("row%0d_core_load", r), 32'(core_load), 32'(vecs[r].e_load));
      check($sformatf("row%0d_out_valid", r), 32'(out_valid), 32'(vecs[r].e_ov));
      if (vecs[r].e_ov) begin
        check($sformatf("row%0d_out_nonce", r), out_nonce, vecs[r].e_nonce);
        check($sformatf("row%0d_out_id", r), 32'(out_id), 32'(vecs[r].e_id));
      end
      if (vecs[r].e_load)
        check($sformatf("row%0d_core_data", r), core_data, vecs[r].wdata);
    end

    // Held output with core1 golden twice: second is dropped
    drive(0, 0, 0, 4'b0010, 0, 0, 32'h7000);
    step();
    $display("hold1: out_valid=%0b nonce=%h overflow=%0b", out_valid, out_nonce, overflow);
    check("hold1_nonce", out_nonce, 32'h6001);
    check("hold1_overflow", 32'(overflow), 0);
    drive(0, 0, 0, 4'b0010, 0, 0, 32'h8000);
    step();
    $display("hold2: out_valid=%0b nonce=%h overflow=%0b", out_valid, out_nonce, overflow);
    check("hold2_overflow", 32'(overflow), 1);
    check("hold2_out_valid", 32'(out_valid), 1);
    check("hold2_nonce", out_nonce, 32'h6001);
    check("hold2_id", 32'(out_id), 6);
    drive(0, 0, 0, 4'b0000, 0, 1, 32'h0);
    step();
    $display("release1: out_valid=%0b nonce=%h", out_valid, out_nonce);
    check("release1_valid", 32'(out_valid), 1);
    check("release1_nonce", out_nonce, 32'h7001);
    step();
    $display("release2: out_valid=%0b overflow=%0b", out_valid, overflow);
    check("release2_valid", 32'(out_valid), 0);
    check("release2_overflow", 32'(overflow), 1);

    // Wraps on all cores in different cycles
    drive(0, 0, 0, 0, 4'b0001, 1, 0); step();
    drive(0, 0, 0, 0, 4'b0100, 1, 0); step();
    drive(0, 0, 0, 0, 4'b1000, 1, 0); step();
    $display("wrap3: exhausted=%0b", exhausted);
    check("wrap3_exhausted", 32'(exhausted), 0);
    drive(0, 0, 0, 0, 4'b0010, 1, 0); step();
    $display("wrap4: exhausted=%0b ready=%0b", exhausted, work_ready);
    check("wrap4_exhausted", 32'(exhausted), 1);
    check("wrap4_ready", 32'(work_ready), 1);
    drive(0, 0, 0, 4'b0001, 0, 1, 32'hA000); step();
    $display("idle_golden: out_valid=%0b", out_valid);
    check("idle_golden_ignored", 32'(out_valid), 0);
    drive(1, 7, 32'h12345678, 0, 0, 1, 0); step();
    check("reload_core_load", 32'(core_load), 1);
    check("reload_core_data", core_data, 32'h12345678);
    drive(0, 0, 0, 0, 0, 1, 0); step();
    $display("reload: exhausted=%0b load=%0b", exhausted, core_load);
    check("reload_exhausted", 32'(exhausted), 0);
    for (int i = 0; i < 8; i++) step();
    check("reload_run_ready", 32'(work_ready), 1);

    // Fill slots, then reset asynchronously mid-cycle
    drive(0, 0, 0, 4'b1111, 0, 0, 32'h9000); step();
    $display("fill: out_valid=%0b nonce=%h id=%0d", out_valid, out_nonce, out_id);
    check("fill_nonce", out_nonce, 32'h9002);
    check("fill_id", 32'(out_id), 7);
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    $display("async_reset: out_valid=%0b nonce=%h overflow=%0b", out_valid, out_nonce, overflow);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_nonce", out_nonce, 0);
    check("arst_out_id", 32'(out_id), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_core_data", core_data, 0);
    check("arst_ready", 32'(work_ready), 1);
    @(negedge hash_clk);
    reset_n = 1'b1;
    drive(1, 3, 32'h0BADF00D, 0, 0, 1, 0); step();
    check("post_rst_load", 32'(core_load), 1);
    drive(0, 0, 0, 0, 0, 1, 0); step();
    check("post_rst_slots_empty1", 32'(out_valid), 0);
    step();
    check("post_rst_slots_empty2", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
